wb_stage: RTL

- Final pipeline stage of the 5-stage CPU. Sits between the MEM stage and the register file write port.
- Registers the MEM→WB bus and performs load byte/halfword extraction and sign/zero extension on data-SRAM read data.
- Drives the regfile write port, the WB→ID forwarding bus and the debug trace.
- Holds its contents correctly across pipeline stalls and flushes.

---
 rtl/wb_stage_pkg.sv | 37 +++
 rtl/wb_stage_load_align.sv | 34 +++
 rtl/wb_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the write-back stage.
//   - MEM->WB and WB->RF bus widths and their packed layouts
//   - indices into the 6-bit pipeline stall vector
//   - load size encodings used by the load aligner
package wb_stage_pkg;

    localparam int MEM_WB_BUS_W = 77;  // 1+32+1+5+32+1+2+1+2
    localparam int WB_RF_BUS_W  = 38;  // 1+5+32

    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] result;
        logic        is_load;
        logic [1:0]  ld_size;
        logic        ld_signed;
        logic [1:0]  addr_lo;
    } mem_wb_bus_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_rf_bus_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load lane select and sign/zero extension.
//   rdata_i     raw 32-bit word read from memory
//   addr_lo_i   effective address [1:0]
//   size_i      LD_BYTE / LD_HALF / LD_WORD
//   signed_i    1 = sign-extend, 0 = zero-extend
//   data_o      aligned, extended load value
// Misaligned accesses are trapped upstream, so addr_lo_i[0] is ignored for
// halfwords and addr_lo_i is ignored entirely for words.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        if (size_i == LD_BYTE) begin
            data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        end else if (size_i == LD_HALF) begin
            data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: final stage of the 5-stage pipeline.
//   Registers the MEM->WB bus, extracts/extends load data from the data SRAM
//   and drives the regfile write port, the WB->ID forwarding bus and the
//   debug trace.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall[5:0]          stall vector; [4] = MEM held, [5] = WB held
//   flush               kills the instruction entering WB
//   mem_*               MEM->WB bus
//   data_sram_rdata     sync SRAM read data, valid in a load's first WB cycle
//   rf_we/waddr/wdata   regfile write port
//   wb_fwd_*            forwarding copy (write enable ignores stall)
//   debug_wb_*          trace port
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic [31:0]   mem_pc,
    input  logic          mem_rf_we,
    input  logic [AW-1:0] mem_rf_waddr,
    input  logic [DW-1:0] mem_result,
    input  logic          mem_is_load,
    input  logic [1:0]    mem_ld_size,
    input  logic          mem_ld_signed,
    input  logic [1:0]    mem_addr_lo,
    input  logic [DW-1:0] data_sram_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          wb_fwd_we,
    output logic [AW-1:0] wb_fwd_waddr,
    output logic [DW-1:0] wb_fwd_wdata,
    output logic [31:0]   debug_wb_pc,
    output logic [3:0]    debug_wb_rf_wen,
    output logic [AW-1:0] debug_wb_rf_wnum,
    output logic [DW-1:0] debug_wb_rf_wdata
);

    mem_wb_bus_t   mem_bus;
    mem_wb_bus_t   bus_d, bus_q;
    logic          fresh_d, fresh_q;
    logic [DW-1:0] rdata_d, rdata_q;
    logic [DW-1:0] ld_raw;
    logic [DW-1:0] ld_data;
    wb_rf_bus_t    wb_rf;

    // Only the MEM and WB stall bits matter to this stage.
    logic unused_stall_lo;
    assign unused_stall_lo = ^stall[3:0];

    always_comb begin
        mem_bus.valid     = mem_valid;
        mem_bus.pc        = mem_pc;
        mem_bus.rf_we     = mem_rf_we;
        mem_bus.waddr     = mem_rf_waddr;
        mem_bus.result    = mem_result;
        mem_bus.is_load   = mem_is_load;
        mem_bus.ld_size   = mem_ld_size;
        mem_bus.ld_signed = mem_ld_signed;
        mem_bus.addr_lo   = mem_addr_lo;
    end

    // The SRAM presents read data for one cycle only, so it is copied into
    // rdata_q on the load's first WB edge; later stalled cycles replay it.
    always_comb begin
        bus_d   = bus_q;
        fresh_d = 1'b0;
        rdata_d = fresh_q ? data_sram_rdata : rdata_q;
        if (flush || (stall[STALL_MEM] && !stall[STALL_WB])) begin
            bus_d = '0;
        end else if (!stall[STALL_WB]) begin
            bus_d   = mem_bus;
            fresh_d = 1'b1;
        end
    end

    // ---- MEM -> WB stage register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q   <= '0;
            fresh_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            bus_q   <= bus_d;
            fresh_q <= fresh_d;
            rdata_q <= rdata_d;
        end
    end

    assign ld_raw = fresh_q ? data_sram_rdata : rdata_q;

    load_align u_load_align (
        .rdata_i   (ld_raw),
        .addr_lo_i (bus_q.addr_lo),
        .size_i    (bus_q.ld_size),
        .signed_i  (bus_q.ld_signed),
        .data_o    (ld_data)
    );

    // Write only on the last WB cycle so a stalled instruction writes once.
    always_comb begin
        wb_rf.we    = bus_q.valid & bus_q.rf_we & ~stall[STALL_WB];
        wb_rf.waddr = bus_q.waddr;
        wb_rf.wdata = bus_q.is_load ? ld_data : bus_q.result;
    end

    assign rf_we             = wb_rf.we;
    assign rf_waddr          = wb_rf.waddr;
    assign rf_wdata          = wb_rf.wdata;

    // ID must see a held WB value, so forwarding ignores the WB stall.
    assign wb_fwd_we         = bus_q.valid & bus_q.rf_we;
    assign wb_fwd_waddr      = wb_rf.waddr;
    assign wb_fwd_wdata      = wb_rf.wdata;

    assign debug_wb_pc       = bus_q.pc;
    assign debug_wb_rf_wen   = {4{wb_rf.we}};
    assign debug_wb_rf_wnum  = wb_rf.waddr;
    assign debug_wb_rf_wdata = wb_rf.wdata;

endmodule
